// File: rtl/result_pkg.sv
// Shared sizing and packed-entry layout for the result collector and its FIFO.
package result_pkg;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned ENTRY_W = 22;

    localparam int unsigned Y_LSB      = 0;
    localparam int unsigned Y_W        = 8;
    localparam int unsigned S_LSB      = 8;
    localparam int unsigned S_W        = 3;
    localparam int unsigned B_LSB      = 11;
    localparam int unsigned REGIME_LSB = 12;
    localparam int unsigned REGIME_W   = 2;
    localparam int unsigned CYC_LSB    = 14;
    localparam int unsigned CYC_W      = 8;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [CYC_W-1:0]    cycles,
        input logic [REGIME_W-1:0] regime,
        input logic                b,
        input logic [S_W-1:0]      s,
        input logic [Y_W-1:0]      y
    );
        return {cycles, regime, b, s, y};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with separate occupancy count; head reads as zero when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // When full, a same-cycle pop frees the slot the write pointer lands on.
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !clear && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/result_collector.sv
// Detects completion of upstream busy phases and queues a tagged result entry for each.
module result_collector #(
    parameter int unsigned DEPTH = result_pkg::DEPTH,
    parameter int unsigned CNT_W = result_pkg::CNT_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        y,
    input  logic [2:0]                        s,
    input  logic                              b,
    input  logic [1:0]                        regime,
    input  logic                              active,
    input  logic                              clear,
    output logic [result_pkg::ENTRY_W-1:0]    dout,
    output logic                              dout_valid,
    input  logic                              dout_ready,
    output logic [$clog2(DEPTH):0]            count,
    output logic                              overflow
);
    import result_pkg::*;

    localparam int unsigned WIDE_W = CNT_W + CYC_W;

    logic               active_q;
    logic [CNT_W-1:0]   busy_cnt;
    logic               completion;
    logic               start;
    logic               pop;
    logic               push;
    logic               full;
    logic               empty;
    logic [WIDE_W-1:0]  cnt_wide;
    logic [CYC_W-1:0]   cyc_field;
    logic [ENTRY_W-1:0] entry;

    assign completion = active_q & ~active;
    assign start      = ~active_q & active;
    assign dout_valid = ~empty;
    assign pop        = dout_valid & dout_ready;
    assign push       = completion & (~full | pop);

    // Counter may be wider or narrower than the entry field; saturate into it.
    assign cnt_wide  = WIDE_W'(busy_cnt);
    assign cyc_field = (cnt_wide > WIDE_W'(2**CYC_W - 1)) ? '1 : cnt_wide[CYC_W-1:0];
    assign entry     = pack_entry(cyc_field, regime, b, s, y);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q <= 1'b0;
            busy_cnt <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            active_q <= active;
            busy_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            active_q <= active;
            if (start)
                busy_cnt <= CNT_W'(1);
            else if (active && active_q && busy_cnt != '1)
                busy_cnt <= busy_cnt + 1'b1;
            if (completion && full && !pop)
                overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (entry),
        .head  (dout),
        .count (count),
        .empty (empty),
        .full  (full)
    );

endmodule

// File: tb/tb_result_collector.sv
// Randomized and directed bench for result_collector against a queue-based behavioural model.
module tb_result_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  y = '0;
    logic [2:0]  s = '0;
    logic        b = 1'b0;
    logic [1:0]  regime = '0;
    logic        active = 1'b0;
    logic        clear = 1'b0;
    logic        dout_ready = 1'b0;
    logic [21:0] dout;
    logic        dout_valid;
    logic [2:0]  count;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    result_collector #(.DEPTH(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .y          (y),
        .s          (s),
        .b          (b),
        .regime     (regime),
        .active     (active),
        .clear      (clear),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model: stored entries, sticky drop flag, and length of the current high run of active.
    logic [21:0] mq[$];
    bit          m_ovf;
    int unsigned m_run;
    bit          m_prev;

    function automatic logic [7:0] sat8(input int unsigned v);
        return (v > 255) ? 8'hFF : 8'(v);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_ovf  = 0;
            m_run  = 0;
            m_prev = 0;
        end else if (clear) begin
            mq.delete();
            m_ovf  = 0;
            m_run  = 0;
            m_prev = active;
        end else begin
            if (mq.size() != 0 && dout_ready) void'(mq.pop_front());
            if (m_prev && !active) begin
                if (mq.size() < 4) mq.push_back({sat8(m_run), regime, b, s, y});
                else m_ovf = 1;
            end
            if (active) m_run = m_prev ? m_run + 1 : 1;
            m_prev = active;
        end
    end

    always @(negedge clk) begin
        chk("valid",    32'(dout_valid), 32'(mq.size() != 0));
        chk("count",    32'(count),      32'(mq.size()));
        chk("dout",     32'(dout),       32'((mq.size() != 0) ? mq[0] : 22'd0));
        chk("overflow", 32'(overflow),   32'(m_ovf));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int unsigned n, input logic [7:0] yy, input logic [2:0] ss,
                         input logic bb, input logic [1:0] rr);
        active = 1'b1;
        repeat (n) tick();
        active = 1'b0;
        y = yy; s = ss; b = bb; regime = rr;
        tick();
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        rst = 1'b1;
        tick();

        // Single 5-cycle operation.
        pulse(5, 8'h19, 3'd3, 1'b1, 2'd2);
        chk("single_valid", 32'(dout_valid), 32'd1);
        chk("single_dout", 32'(dout), 32'h16B19);
        chk("single_count", 32'(count), 32'd1);

        // Overfill, then drain in order.
        for (int i = 0; i < 4; i++) pulse(i + 1, 8'(8'h20 + i), 3'(i), 1'b0, 2'(i));
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_head", 32'(dout), 32'h16B19);
        dout_ready = 1'b1;
        tick();
        chk("drain_second", 32'(dout[7:0]), 32'h20);
        repeat (3) tick();
        chk("drain_empty", 32'(dout_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        dout_ready = 1'b0;

        // Full FIFO with push and pop in the same cycle.
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clear_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) pulse(2, 8'(8'h40 + i), 3'd1, 1'b1, 2'd1);
        active = 1'b1; tick();
        active = 1'b0; y = 8'hAB; dout_ready = 1'b1; tick();
        dout_ready = 1'b0;
        chk("pp_count", 32'(count), 32'd4);
        chk("pp_ovf", 32'(overflow), 32'd0);
        chk("pp_head", 32'(dout[7:0]), 32'h41);
        dout_ready = 1'b1;
        repeat (3) tick();
        chk("pp_last", 32'(dout[7:0]), 32'hAB);
        tick();
        chk("pp_empty", 32'(dout_valid), 32'd0);
        dout_ready = 1'b0;

        // Saturating busy count.
        pulse(300, 8'h77, 3'd1, 1'b0, 2'd1);
        chk("sat_cycles", 32'(dout[21:14]), 32'd255);
        clear = 1'b1; tick(); clear = 1'b0;

        // Clear coinciding with a falling edge of active.
        pulse(1, 8'h01, 3'd0, 1'b0, 2'd0);
        pulse(1, 8'h02, 3'd0, 1'b0, 2'd0);
        chk("pre_clear_count", 32'(count), 32'd2);
        active = 1'b1; tick();
        active = 1'b0; clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_valid", 32'(dout_valid), 32'd0);
        tick();
        chk("clr_no_push", 32'(count), 32'd0);

        // Asynchronous reset mid-operation.
        pulse(1, 8'h03, 3'd0, 1'b0, 2'd0);
        pulse(1, 8'h04, 3'd0, 1'b0, 2'd0);
        active = 1'b1; tick(); tick();
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 32'(dout_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_dout", 32'(dout), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        tick();
        rst = 1'b1;
        pulse(3, 8'h55, 3'd2, 1'b1, 2'd3);
        chk("post_rst_cycles", 32'(dout[21:14]), 32'd3);
        chk("post_rst_count", 32'(count), 32'd1);

        // Randomized traffic with varying consumer pressure.
        for (int blk = 0; blk < 15; blk++) begin
            int unsigned ready_pct;
            ready_pct = $urandom_range(0, 100);
            for (int c = 0; c < 200; c++) begin
                if (active) active = ($urandom_range(0, 3) != 0);
                else        active = ($urandom_range(0, 2) == 0);
                y          = 8'($urandom);
                s          = 3'($urandom);
                b          = 1'($urandom);
                regime     = 2'($urandom);
                dout_ready = ($urandom_range(0, 99) < ready_pct);
                clear      = ($urandom_range(0, 99) == 0);
                if ($urandom_range(0, 399) == 0) begin
                    rst = 1'b0;
                    tick();
                    rst = 1'b1;
                end else begin
                    tick();
                end
            end
        end
        clear = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
